dvp_tx: RTL and testbench

//  Camera-side DVP transmitter: the sending end of the interface that capture receives.

---
 rtl/dvp_tx.sv | 136 +++++++++++++
 tb/tb_dvp_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_tx.sv
// dvp_tx: camera-side DVP transmitter turning FIFO pixels into vsync/href/byte frames
module dvp_tx #(
    parameter int         H_ACTIVE      = 640,
    parameter int         V_ACTIVE      = 480,
    parameter int         VSYNC_CYCLES  = 4704,
    parameter int         VBP_CYCLES    = 26656,
    parameter int         HBLANK_CYCLES = 288,
    parameter logic [3:0] PAD_NIBBLE    = 4'hF,
    parameter int         CNT_W         = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_enable,
    output logic        o_rd,
    input  logic [11:0] i_data,
    input  logic        i_empty,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_frame_done,
    output logic        o_underflow
);
    localparam int ROW_W = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(VBP_CYCLES - 1);
    localparam logic [CNT_W-1:0] VBP_RD   = CNT_W'(VBP_CYCLES - 2);
    localparam logic [CNT_W-1:0] LN_LAST  = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LN_RD    = CNT_W'(2 * H_ACTIVE - 3);
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HBLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HB_RD    = CNT_W'(HBLANK_CYCLES - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ROW_W-1:0]   r_row;
    logic               r_rd_due;
    logic               r_valid;
    logic [7:0]         r_odd;
    logic               r_vsync;
    logic               r_href;
    logic [7:0]         r_data;
    logic               r_done;
    logic               r_under;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [11:0]        w_pix;

    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_pix        = r_valid ? i_data : 12'h000;
    assign o_rd         = r_rd_due & ~i_empty;
    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_data       = r_data;
    assign o_frame_done = r_done;
    assign o_underflow  = r_under;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_row    <= '0;
            r_rd_due <= 1'b0;
            r_valid  <= 1'b0;
            r_odd    <= '0;
            r_vsync  <= 1'b0;
            r_href   <= 1'b0;
            r_data   <= '0;
            r_done   <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_rd_due <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= o_rd;
            r_cnt    <= w_cnt_inc;
            if (r_rd_due && i_empty) r_under <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_enable) begin
                        r_state <= S_VSYNC;
                        r_vsync <= 1'b1;
                    end
                end
                S_VSYNC: if (r_cnt == VS_LAST) begin
                    r_state  <= S_VBP;
                    r_vsync  <= 1'b0;
                    r_cnt    <= '0;
                    r_rd_due <= (VBP_RD == '0);
                end
                S_VBP: if (r_cnt == VBP_LAST) begin
                    r_state  <= S_LINE;
                    r_row    <= '0;
                    r_cnt    <= '0;
                    r_href   <= 1'b1;
                    r_data   <= {PAD_NIBBLE, w_pix[11:8]};
                    r_odd    <= w_pix[7:0];
                    r_rd_due <= (H_ACTIVE > 1);
                end else begin
                    r_rd_due <= (w_cnt_inc == VBP_RD);
                end
                S_LINE: if (r_cnt == LN_LAST) begin
                    r_state  <= S_HBLANK;
                    r_href   <= 1'b0;
                    r_data   <= '0;
                    r_cnt    <= '0;
                    r_rd_due <= (HB_RD == '0) && (r_row != ROW_LAST);
                end else if (r_cnt[0]) begin
                    r_data   <= {PAD_NIBBLE, w_pix[11:8]};
                    r_odd    <= w_pix[7:0];
                    r_rd_due <= (H_ACTIVE > 1) && (r_cnt < LN_RD);
                end else begin
                    r_data <= r_odd;
                end
                S_HBLANK: if (r_cnt == HB_LAST) begin
                    r_cnt <= '0;
                    if (r_row != ROW_LAST) begin
                        r_state  <= S_LINE;
                        r_row    <= r_row + 1'b1;
                        r_href   <= 1'b1;
                        r_data   <= {PAD_NIBBLE, w_pix[11:8]};
                        r_odd    <= w_pix[7:0];
                        r_rd_due <= (H_ACTIVE > 1);
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= i_enable ? S_VSYNC : S_IDLE;
                        r_vsync <= i_enable;
                    end
                end else begin
                    r_rd_due <= (w_cnt_inc == HB_RD) && (r_row != ROW_LAST);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: frame-timeline model plus directed literal checks for dvp_tx
module tb_dvp_tx;
    localparam int H = 4, V = 3, VS = 5, VBP = 6, HB = 3;
    localparam int LT = 2 * H + HB;
    localparam int FRAME = VS + VBP + V * LT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        o_rd;
    logic [11:0] fifo_dout = '0;
    logic        i_empty;
    logic        o_vsync, o_href, o_frame_done, o_underflow;
    logic [7:0]  o_data;

    logic [11:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          total = 0;
    int          bad = 0;
    int          n_vs = 0, n_href = 0, n_rd = 0, n_done = 0;

    dvp_tx #(
        .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_CYCLES(VS), .VBP_CYCLES(VBP),
        .HBLANK_CYCLES(HB), .PAD_NIBBLE(4'hF), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_enable(en), .o_rd(o_rd),
        .i_data(fifo_dout), .i_empty(i_empty), .o_vsync(o_vsync), .o_href(o_href),
        .o_data(o_data), .o_frame_done(o_frame_done), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    assign i_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (o_rd) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, a, e, $time);
        end
    endtask

    function automatic int pix_at(input int tt);
        int u, k;
        if (tt < VS + VBP || tt >= FRAME) return -1;
        u = tt - VS - VBP;
        k = u % LT;
        if (k >= 2 * H || (k % 2) != 0) return -1;
        return (u / LT) * H + k / 2;
    endfunction

    int          m_act = 0, m_t = 0, m_pop = 0;
    bit          m_done = 0, m_under = 0;
    logic [11:0] m_pix [0:H*V-1];
    int          nxt, u, k;
    logic        e_vs, e_hr, e_rd;
    logic [7:0]  e_d;
    logic [11:0] p;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 0;
            m_done = 0;
            m_under = 0;
        end else begin
            e_vs = (m_act != 0) && m_t < VS;
            e_hr = 1'b0;
            e_d = 8'h00;
            e_rd = 1'b0;
            if (m_act != 0 && m_t >= VS + VBP) begin
                u = m_t - VS - VBP;
                k = u % LT;
                if (k < 2 * H) begin
                    e_hr = 1'b1;
                    p = m_pix[(u / LT) * H + k / 2];
                    e_d = (k % 2 != 0) ? p[7:0] : {4'hF, p[11:8]};
                end
            end
            nxt = (m_act != 0) ? pix_at(m_t + 2) : -1;
            if (nxt >= 0) begin
                if (wr_ptr != m_pop) begin
                    e_rd = 1'b1;
                    m_pix[nxt] = mem[m_pop];
                    m_pop++;
                end else begin
                    m_pix[nxt] = 12'h000;
                end
            end
            chk("vsync", 16'(o_vsync), 16'(e_vs));
            chk("href", 16'(o_href), 16'(e_hr));
            chk("data", 16'(o_data), 16'(e_d));
            chk("rd", 16'(o_rd), 16'(e_rd));
            chk("frame_done", 16'(o_frame_done), 16'(m_done));
            chk("underflow", 16'(o_underflow), 16'(m_under));
            if (nxt >= 0 && !e_rd) m_under = 1;
            n_vs += int'(o_vsync);
            n_href += int'(o_href);
            n_rd += int'(o_rd);
            n_done += int'(o_frame_done);
            if (m_act == 0) begin
                m_done = 0;
                if (en) begin
                    m_act = 1;
                    m_t = 0;
                end
            end else if (m_t == FRAME - 1) begin
                m_done = 1;
                if (en) m_t = 0;
                else m_act = 0;
            end else begin
                m_done = 0;
                m_t++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) tick(1);
        chk("frame_done_count", 16'(n_done), 16'(target));
    endtask

    task automatic wait_href();
        for (int i = 0; i < 60 && !o_href; i++) tick(1);
        chk("href_wait", 16'(o_href), 16'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_vsync"}, 16'(o_vsync), 16'd0);
        chk({nm, "_href"}, 16'(o_href), 16'd0);
        chk({nm, "_data"}, 16'(o_data), 16'd0);
        chk({nm, "_rd"}, 16'(o_rd), 16'd0);
        chk({nm, "_done"}, 16'(o_frame_done), 16'd0);
        chk({nm, "_under"}, 16'(o_underflow), 16'd0);
    endtask

    logic [7:0] lit [8] = '{8'hFA, 8'hBC, 8'hF1, 8'h23, 8'hF4, 8'h56, 8'hF7, 8'h89};
    int snap;

    initial begin
        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(2);
        push(12'hABC); push(12'h123); push(12'h456); push(12'h789);
        for (int i = 0; i < 20; i++) push(12'(12'h300 + 7 * i));
        en = 1'b1;
        wait_href();
        for (int i = 0; i < 8; i++) begin
            chk("row0_byte", 16'(o_data), 16'(lit[i]));
            tick(1);
        end
        chk("row0_gap_href", 16'(o_href), 16'd0);
        wait_done(1);
        chk("f1_rd_pulses", 16'(n_rd), 16'd12);
        chk("f1_href_cycles", 16'(n_href), 16'd24);
        tick(22);
        en = 1'b0;
        wait_done(2);
        tick(10);
        chk("f2_vsync_cycles", 16'(n_vs), 16'd10);
        chk("f2_href_cycles", 16'(n_href), 16'd48);
        chk("f2_rd_pulses", 16'(n_rd), 16'd24);
        chk("idle_vsync", 16'(o_vsync), 16'd0);
        chk("idle_rd", 16'(o_rd), 16'd0);
        for (int i = 1; i <= 6; i++) push(12'(12'h111 * i));
        en = 1'b1;
        tick(1);
        chk("uf_vsync_start", 16'(o_vsync), 16'd1);
        en = 1'b0;
        tick(22);
        chk("uf_row1_px0", 16'(o_data), 16'h00F5);
        tick(4);
        chk("uf_px_even", 16'(o_data), 16'h00F0);
        chk("uf_href", 16'(o_href), 16'd1);
        chk("uf_flag", 16'(o_underflow), 16'd1);
        tick(1);
        chk("uf_px_odd", 16'(o_data), 16'h0000);
        wait_done(3);
        tick(3);
        chk("uf_sticky", 16'(o_underflow), 16'd1);
        for (int i = 0; i < 24; i++) push(12'(12'h800 + i));
        en = 1'b1;
        wait_href();
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        snap = n_vs;
        tick(10);
        chk("no_vsync_while_disabled", 16'(n_vs - snap), 16'd0);
        chk("post_rst_idle", 16'(o_vsync), 16'd0);
        en = 1'b1;
        tick(1);
        chk("post_rst_vsync", 16'(o_vsync), 16'd1);
        en = 1'b0;
        wait_done(4);
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
